// File: rtl/stream_mux_rr.sv
`timescale 1ns/1ps
// N-input packet-locked stream mux with round-robin or fixed-priority arbitration
// and a single registered valid/ready output stage.
module stream_mux_rr #(
    parameter int WIDTH         = 32,
    parameter int N             = 4,
    parameter int PRIORITY_MODE = 0,
    localparam int GW           = (N > 1) ? $clog2(N) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N-1:0]       IN_VALID,
    input  logic [N*WIDTH-1:0] IN_DATA,
    input  logic [N-1:0]       IN_LAST,
    output logic [N-1:0]       IN_READY,
    output logic               OUT_VALID,
    output logic [WIDTH-1:0]   OUT_DATA,
    output logic               OUT_LAST,
    output logic [GW-1:0]      OUT_CH,
    input  logic               OUT_READY
);

    typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_e;

    localparam logic [GW-1:0] LAST_CH = GW'(N - 1);

    state_e            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     pick_s;
    logic [N-1:0]      ready_s;
    logic              can_load_s;
    logic              accept_s;
    logic [WIDTH-1:0]  sel_data_s;
    logic              sel_last_s;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [GW-1:0]     out_ch_q, out_ch_d;

    // First requester at or above base, wrapping; result is always < N.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] req, input logic [GW-1:0] base);
        logic [2*N-1:0] dbl;
        int pos;
        dbl = {req, req} >> base;
        pos = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (dbl[k]) pos = k;
        end
        pos = (int'(base) + pos) % N;
        return pos[GW-1:0];
    endfunction

    assign pick_s     = rr_pick(IN_VALID, (PRIORITY_MODE != 0) ? '0 : rr_ptr_q);
    assign can_load_s = !out_valid_q || OUT_READY;
    assign accept_s   = |(ready_s & IN_VALID);

    // Steer the granted channel's beat; only indices below N can ever match.
    always_comb begin
        sel_data_s = '0;
        sel_last_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data_s = IN_DATA[i*WIDTH +: WIDTH];
                sel_last_s = IN_LAST[i];
            end else begin
                sel_data_s = sel_data_s;
                sel_last_s = sel_last_s;
            end
        end
    end

    // Arbitration state, grant and round-robin pointer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state: lock on a pick, release after an accepted last beat.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (|IN_VALID) begin
                    state_d = S_LOCKED;
                    grant_d = pick_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (accept_s && sel_last_s) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (grant_q == LAST_CH) ? '0 : grant_q + GW'(1'b1);
                end else begin
                    state_d = S_LOCKED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready goes only to the locked channel, and only when the output can take a beat.
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < N; i++) begin
            if (state_q == S_LOCKED && grant_q == GW'(i)) begin
                ready_s[i] = can_load_s;
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    // Output register: load on accept, drain on downstream ready, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_last_d  = sel_last_s;
            out_ch_d    = grant_q;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output stage registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign IN_READY  = ready_s;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_LAST  = out_last_q;
    assign OUT_CH    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
`timescale 1ns/1ps
// Directed bench: round-robin order, reset, lock through a source gap,
// fixed priority, backpressure and pointer wrap with N=3.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  rr_valid, rr_last, rr_ready;
    logic [31:0] rr_data;
    logic        rr_ov, rr_ol, rr_or;
    logic [7:0]  rr_od;
    logic [1:0]  rr_och;

    logic [3:0]  fp_valid, fp_last, fp_ready;
    logic [31:0] fp_data;
    logic        fp_ov, fp_ol, fp_or;
    logic [7:0]  fp_od;
    logic [1:0]  fp_och;

    logic [2:0]  n3_valid, n3_last, n3_ready;
    logic [23:0] n3_data;
    logic        n3_ov, n3_ol, n3_or;
    logic [7:0]  n3_od;
    logic [1:0]  n3_och;

    stream_mux_rr #(.WIDTH(8), .N(4), .PRIORITY_MODE(0)) u_rr (
        .CLK(clk), .RST(rst), .IN_VALID(rr_valid), .IN_DATA(rr_data), .IN_LAST(rr_last),
        .IN_READY(rr_ready), .OUT_VALID(rr_ov), .OUT_DATA(rr_od), .OUT_LAST(rr_ol),
        .OUT_CH(rr_och), .OUT_READY(rr_or));

    stream_mux_rr #(.WIDTH(8), .N(4), .PRIORITY_MODE(1)) u_fp (
        .CLK(clk), .RST(rst), .IN_VALID(fp_valid), .IN_DATA(fp_data), .IN_LAST(fp_last),
        .IN_READY(fp_ready), .OUT_VALID(fp_ov), .OUT_DATA(fp_od), .OUT_LAST(fp_ol),
        .OUT_CH(fp_och), .OUT_READY(fp_or));

    stream_mux_rr #(.WIDTH(8), .N(3), .PRIORITY_MODE(0)) u_n3 (
        .CLK(clk), .RST(rst), .IN_VALID(n3_valid), .IN_DATA(n3_data), .IN_LAST(n3_last),
        .IN_READY(n3_ready), .OUT_VALID(n3_ov), .OUT_DATA(n3_od), .OUT_LAST(n3_ol),
        .OUT_CH(n3_och), .OUT_READY(n3_or));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [3:0] rr_beat;
    int b0, b1, gap, lk_out;
    int bp_b, bp_out;
    logic s0, s1, s2;
    int n3_out;
    logic v0, v1;

    initial begin
        rst = 1'b1;
        rr_valid = 4'b0; rr_last = 4'b0; rr_data = 32'b0; rr_or = 1'b1;
        fp_valid = 4'b0; fp_last = 4'b0; fp_data = 32'b0; fp_or = 1'b1;
        n3_valid = 3'b0; n3_last = 3'b0; n3_data = 24'b0; n3_or = 1'b1;
        rr_beat = 4'b0;
        repeat (2) @(negedge clk);
        check("rst_ov", 32'(rr_ov), 32'd0);
        check("rst_ready", 32'(rr_ready), 32'd0);
        rst = 1'b0;

        // Round-robin: all channels valid, 2-beat packets.
        for (int t = 0; t < 18; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                int k, ch;
                k  = t - 2;
                ch = (k / 3) % 4;
                check("rr_valid", 32'(rr_ov), 32'((k % 3) != 2));
                if ((k % 3) != 2) begin
                    check("rr_ch", 32'(rr_och), 32'(ch));
                    check("rr_data", 32'(rr_od), 32'(((k % 3) == 0 ? 8'hA0 : 8'hB0) + ch));
                    check("rr_last", 32'(rr_ol), 32'((k % 3) == 1));
                end
            end
            for (int i = 0; i < 4; i++) begin
                rr_valid[i]       = 1'b1;
                rr_data[i*8 +: 8] = rr_beat[i] ? 8'(8'hB0 + i) : 8'(8'hA0 + i);
                rr_last[i]        = rr_beat[i];
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                if (rr_ready[i] && rr_valid[i]) rr_beat[i] = ~rr_beat[i];
            end
        end

        // Asynchronous reset while ch1 is mid-packet with a beat on the output.
        rst = 1'b1;
        #1;
        check("arst_ov", 32'(rr_ov), 32'd0);
        check("arst_data", 32'(rr_od), 32'd0);
        check("arst_last", 32'(rr_ol), 32'd0);
        check("arst_ch", 32'(rr_och), 32'd0);
        check("arst_ready", 32'(rr_ready), 32'd0);
        @(negedge clk);
        check("arst_hold_ov", 32'(rr_ov), 32'd0);
        rst = 1'b0;

        // Lock held through a 3-cycle source gap on ch0 while ch1 waits.
        b0 = 0; b1 = 0; gap = 0; lk_out = 0;
        for (int j = 0; j < 18; j++) begin
            if (j > 0) @(negedge clk);
            if (rr_ov) begin
                check("lock_ch", 32'(rr_och), (lk_out < 3) ? 32'd0 : 32'd1);
                check("lock_data", 32'(rr_od), (lk_out < 3) ? 32'(8'hC0 + lk_out) : 32'h0000_00D1);
                lk_out++;
            end
            v0 = (b0 < 3) && !(b0 == 1 && gap < 3);
            if (b0 == 1 && gap < 3) gap++;
            v1 = (b1 < 1);
            rr_valid = {2'b00, v1, v0};
            rr_data  = {16'h0000, 8'hD1, 8'(8'hC0 + b0)};
            rr_last  = {2'b00, 1'b1, b0 == 2};
            #1;
            if (j == 1) check("post_rst_grant", 32'(rr_ready), 32'h0000_0001);
            if (b0 < 3) check("lock_hold", 32'(rr_ready[1]), 32'd0);
            if (rr_ready[0] && v0) b0++;
            if (rr_ready[1] && v1) b1++;
        end
        check("lock_count", 32'(lk_out), 32'd4);

        // Fixed priority: ch1 and ch3 always valid, 1-beat packets.
        for (int t = 0; t <= 10; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                check("fp_valid", 32'(fp_ov), 32'(t >= 2 && (t % 2) == 0));
                if (fp_ov) begin
                    check("fp_ch", 32'(fp_och), 32'd1);
                    check("fp_data", 32'(fp_od), 32'h0000_0051);
                end
            end
            fp_valid = (t < 10) ? 4'b1010 : 4'b0000;
            fp_data  = {8'h53, 8'h00, 8'h51, 8'h00};
            fp_last  = 4'b1111;
            #1;
            if (t <= 9) check("fp_ready", 32'(fp_ready), (t % 2 == 1) ? 32'h0000_0002 : 32'd0);
        end

        // Backpressure: ch2 sends 0x11,0x22,0x33 while OUT_READY toggles.
        bp_b = 0; bp_out = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            fp_or    = (c % 2) == 1;
            fp_valid = {1'b0, bp_b < 3, 2'b00};
            fp_data  = {8'h00, 8'(8'h11 * (bp_b + 1)), 16'h0000};
            fp_last  = {1'b0, bp_b == 2, 2'b00};
            #1;
            if (fp_ov) begin
                if (bp_out < 3) begin
                    check("bp_data", 32'(fp_od), 32'(8'h11 * (bp_out + 1)));
                    check("bp_last", 32'(fp_ol), 32'(bp_out == 2));
                    check("bp_ch", 32'(fp_och), 32'd2);
                end else begin
                    check("bp_extra", 32'(fp_ov), 32'd0);
                end
                if (fp_or) bp_out++;
            end
            if (fp_ov && !fp_or) check("bp_stall_ready", 32'(fp_ready[2]), 32'd0);
            if (fp_ready[2] && fp_valid[2]) bp_b++;
        end
        check("bp_out_count", 32'(bp_out), 32'd3);
        check("bp_in_count", 32'(bp_b), 32'd3);

        // N=3 wrap: ch2 first, then ch0 and ch1 together; ch0 must win.
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; n3_out = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (n3_ov) begin
                int ech;
                ech = (n3_out == 0) ? 2 : (n3_out == 1) ? 0 : 1;
                check("n3_ch", 32'(n3_och), 32'(ech));
                check("n3_data", 32'(n3_od), 32'(8'h70 + ech));
                n3_out++;
            end
            n3_valid = {!s2, s2 && !s1, s2 && !s0};
            n3_data  = {8'h72, 8'h71, 8'h70};
            n3_last  = 3'b111;
            #1;
            if (n3_ready[0] && n3_valid[0]) s0 = 1'b1;
            if (n3_ready[1] && n3_valid[1]) s1 = 1'b1;
            if (n3_ready[2] && n3_valid[2]) s2 = 1'b1;
        end
        check("n3_count", 32'(n3_out), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-input, WIDTH-bit stream multiplexer with packet-level round-robin (or fixed-priority) arbitration and a registered valid/ready output stage. It is the sequential successor of the plain 2:1 datapath mux. Where the 2:1 mux steers one word combinationally under an external select, this block makes its own selection. It locks one source for a whole packet (until a beat with `LAST`) and decouples producer from consumer through one output register. It sits between multiple bus/stream masters (e.g. fetch, load/store, debug) and a single downstream consumer.

## Interface
Parameters:
- `WIDTH`, 32, data width in bits (≥1).
- `N`, 4, number of input channels (≥2). `GW = $clog2(N)`.
- `PRIORITY_MODE`, 0. 0 = round-robin. 1 = fixed priority, lowest index wins.

Ports:
- `CLK`  in  1  clock. All state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `IN_VALID`  in  N  per-channel beat valid.
- `IN_DATA`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `IN_LAST`  in  N  per-channel last-beat-of-packet flag.
- `IN_READY`  out  N  per-channel accept. At most one bit is high.
- `OUT_VALID`  out  1  output register holds a beat.
- `OUT_DATA`  out  WIDTH  output beat data.
- `OUT_LAST`  out  1  output beat last flag.
- `OUT_CH`  out  GW  source channel index of the beat in the output register.
- `OUT_READY`  in  1  downstream accept.

## Operation
- **Handshake:** a beat transfers when `VALID && READY` at a rising edge, on both input and output sides.
- **IDLE state:**
  - No channel is locked and all `IN_READY` are 0.
  - If any `IN_VALID` is 1, the arbiter picks a winner, registers it as `grant`, and moves to LOCKED.
  - If no `IN_VALID` is set, it stays in IDLE.
- **Round-robin pick (mode 0):** the first valid channel scanning upward from `rr_ptr`, wrapping from N-1 to 0.
- **Fixed-priority pick (mode 1):** the lowest-index valid channel. `rr_ptr` is ignored.
- **LOCKED state:**
  - `IN_READY[grant] = !OUT_VALID || OUT_READY`. All other bits are 0.
  - Each accepted beat loads `OUT_DATA`, `OUT_LAST` and `OUT_CH=grant`, and sets `OUT_VALID`.
  - An accepted beat with `IN_LAST=1` returns the block to IDLE and sets `rr_ptr = grant+1` (mod N).
- **Output register:**
  - If a new beat is accepted, it loads the beat.
  - Otherwise, if `OUT_READY` is 1, `OUT_VALID` clears; data and last hold their old values.
  - Otherwise it holds.
- **Stable output:** `OUT_DATA`, `OUT_LAST` and `OUT_CH` stay stable while `OUT_VALID && !OUT_READY`.
- **Source-side rule:** a locked channel that drops `IN_VALID` mid-packet keeps the lock. There is no timeout, and other channels wait.
- **Data selection:** selection uses `grant` only, never the raw `IN_VALID` vector.

## Timing
- **Reset values (async assert):**
  - State = IDLE, `grant=0`, `rr_ptr=0`.
  - `IN_READY=0`, `OUT_VALID=0`, `OUT_DATA=0`, `OUT_LAST=0`, `OUT_CH=0`.
- **Reset release:** deassertion is taken synchronously on the next edge by the surrounding reset synchroniser; the block assumes no extra behaviour.
- **Reset mid-packet:** the lock, the output beat and the pointer are discarded. There is no partial-packet recovery.
- **Arbitration cost:** 1 cycle from the IDLE cycle where `IN_VALID` is seen to the first `IN_READY`.
- **Beat latency:** 1 cycle from input acceptance to `OUT_VALID`.
- **Throughput in LOCKED:** 1 beat/cycle while `OUT_READY=1`.
- **Packet gap:** a minimum 1-cycle IDLE gap follows every last beat.
- **Single-beat packet:** `IN_VALID && IN_LAST` on the first beat gives 1 beat per 2 cycles.
- **Backpressure:** when `OUT_VALID=1` and `OUT_READY=0`, `IN_READY` is 0 in that same cycle.
- **Simultaneous drain and fill:** with `OUT_VALID=1` and `OUT_READY=1` and the input beat valid, the output is drained and reloaded in the same edge with no bubble.
- **Pointer wrap:** `rr_ptr` wraps from N-1 to 0. Non-power-of-2 N must wrap correctly, e.g. N=3: ptr 2 → 0.
- **Unused codes:** the arbiter must never grant an index ≥ N.

## Test plan
- **Reset values:** assert `RST` mid-packet with `OUT_VALID=1`. Required: all outputs 0 immediately (asynchronously), and after release the block is in IDLE with `rr_ptr=0`.
- **Round-robin order:** N=4, mode 0, all four channels valid with 2-beat packets (data `0xA0+i`, `0xB0+i`), `OUT_READY=1`. Required: output order ch0,ch0,ch1,ch1,ch2,ch2,ch3,ch3,ch0…, with `OUT_CH` matching and a 1-cycle gap between packets.
- **Fixed priority:** mode 1, ch1 and ch3 permanently valid with 1-beat packets. Required: only ch1 is ever granted, and ch3 starves.
- **Backpressure:** ch2 sends `0x11`, `0x22`, `0x33` (last on the third beat) while `OUT_READY` toggles 0/1 each cycle. Required: `0x11`, `0x22`, `0x33` appear in order, no beat is duplicated or lost, and `OUT_DATA` holds while stalled.
- **Lock held through a gap:** ch0 drops `IN_VALID` for 3 cycles mid-packet while ch1 is valid. Required: ch1 is not granted until ch0's last beat is accepted.
- **Wrap and odd N:** N=3, ch2 then ch0 each send 1-beat packets. Required: the grant after ch2 is ch0, `rr_ptr` becomes 0, and `OUT_CH` never equals 3.
